// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage of the rv32imc core.
// Issues load/store requests to the data memory with a request/response
// handshake, lane-aligns store data and byte masks, aligns and extends load
// data, stalls upstream while an access is outstanding, and registers the
// result into mem_stage_reg for writeback/forwarding.
//
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   ex_stage_reg   execute-stage register (address/result, store data, ctrl)
//   dmem_addr      word-aligned data memory address
//   dmem_rmask     byte read enables, nonzero only in the issue cycle
//   dmem_wmask     byte write enables, nonzero only in the issue cycle
//   dmem_wdata     lane-shifted store data
//   dmem_rdata     read data, valid with dmem_resp
//   dmem_resp      access-complete pulse
//   o_mem_stall    freezes IF/ID/EX registers
//   mem_stage_reg  registered result to writeback/forwarding
//
// Optional feature: define MEM_STAGE_RVFI_MEM_EN to capture the rvfi memory
// fields on the response cycle; otherwise they are tied to zero.

package mem_stage_pkg;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NBYTES = XLEN / 8;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic       mem_re;
        logic       mem_we;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regf_we;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    // rvfi fields produced upstream of the memory stage
    typedef struct packed {
        logic            valid;
        logic [63:0]     order;
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
    } rvfi_core_t;

    // full rvfi record leaving the memory stage
    typedef struct packed {
        logic              valid;
        logic [63:0]       order;
        logic [XLEN-1:0]   insn;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [NBYTES-1:0] mem_rmask;
        logic [NBYTES-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_wdata;
        logic [XLEN-1:0]   mem_rdata;
    } rvfi_t;

    typedef struct packed {
        logic [XLEN-1:0]   alu_out;
        logic [XLEN-1:0]   rs2_rdata;
        logic [REG_AW-1:0] rd_addr;
        mem_ctrl_t         mem_ctrl;
        wb_ctrl_t          wb_ctrl;
        rvfi_core_t        rvfi;
    } ex_stage_t;

    typedef struct packed {
        logic [XLEN-1:0]   alu_out;
        logic [XLEN-1:0]   mem_rdata;
        logic [REG_AW-1:0] rd_addr;
        wb_ctrl_t          wb_ctrl;
        rvfi_t             rvfi;
    } mem_stage_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  ex_stage_t           ex_stage_reg,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [NBYTES-1:0]   dmem_rmask,
    output logic [NBYTES-1:0]   dmem_wmask,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_resp,
    output logic                o_mem_stall,
    output mem_stage_t          mem_stage_reg
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        byte_off;
    logic [2:0]        funct3;
    logic              is_load, is_store, is_mem;
    logic              size_byte, size_half, size_word;
    logic              misaligned;
    logic              issue;
    logic              complete;
    logic [NBYTES-1:0] lane_mask;
    logic [XLEN-1:0]   raw_rdata;
    logic [XLEN-1:0]   load_ext;
    mem_stage_t        mem_d;

    assign byte_off  = ex_stage_reg.alu_out[1:0];
    assign funct3    = ex_stage_reg.mem_ctrl.funct3;
    assign is_load   = ex_stage_reg.mem_ctrl.mem_re;
    assign is_store  = ex_stage_reg.mem_ctrl.mem_we & ~ex_stage_reg.mem_ctrl.mem_re;
    assign is_mem    = is_load | is_store;

    // access size from funct3[1:0]; unsupported encodings are treated as word
    assign size_byte = (funct3[1:0] == 2'b00);
    assign size_half = (funct3[1:0] == 2'b01);
    assign size_word = funct3[1];

    assign misaligned = (size_half & byte_off[0]) | (size_word & (byte_off != 2'b00));

    // byte lanes touched by the access
    always_comb begin
        lane_mask = 4'b0001 << byte_off;
        if (size_half) begin
            lane_mask = 4'b0011 << byte_off;
        end else if (size_word) begin
            lane_mask = 4'b1111;
        end
    end

    // request issued only from IDLE for an aligned memory op
    assign issue = (state_q == S_IDLE) & is_mem & ~misaligned;

    assign dmem_addr  = {ex_stage_reg.alu_out[XLEN-1:2], 2'b00};
    assign dmem_rmask = (issue & is_load)  ? lane_mask : '0;
    assign dmem_wmask = (issue & is_store) ? lane_mask : '0;
    assign dmem_wdata = ex_stage_reg.rs2_rdata << {byte_off, 3'b000};

    // load alignment and extension
    assign raw_rdata = dmem_rdata >> {byte_off, 3'b000};

    always_comb begin
        case (funct3)
            3'b000:  load_ext = {{24{raw_rdata[7]}},  raw_rdata[7:0]};
            3'b001:  load_ext = {{16{raw_rdata[15]}}, raw_rdata[15:0]};
            3'b100:  load_ext = {24'd0, raw_rdata[7:0]};
            3'b101:  load_ext = {16'd0, raw_rdata[15:0]};
            default: load_ext = raw_rdata;
        endcase
    end

`ifdef MEM_STAGE_RVFI_MEM_EN
    // issued masks held for the rvfi record captured at response time
    logic [NBYTES-1:0] rvfi_rmask_q, rvfi_wmask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvfi_rmask_q <= '0;
            rvfi_wmask_q <= '0;
        end else if (issue) begin
            rvfi_rmask_q <= dmem_rmask;
            rvfi_wmask_q <= dmem_wmask;
        end
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and stall
    always_comb begin
        state_d     = state_q;
        o_mem_stall = 1'b0;
        complete    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    o_mem_stall = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem_resp) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    o_mem_stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // next value of the stage register: pass-through, load result or bubble
    always_comb begin
        mem_d                = '0;
        mem_d.alu_out        = ex_stage_reg.alu_out;
        mem_d.rd_addr        = ex_stage_reg.rd_addr;
        mem_d.wb_ctrl        = ex_stage_reg.wb_ctrl;
        mem_d.rvfi.valid     = ex_stage_reg.rvfi.valid;
        mem_d.rvfi.order     = ex_stage_reg.rvfi.order;
        mem_d.rvfi.insn      = ex_stage_reg.rvfi.insn;
        mem_d.rvfi.pc_rdata  = ex_stage_reg.rvfi.pc_rdata;
        mem_d.rvfi.pc_wdata  = ex_stage_reg.rvfi.pc_wdata;

        // misaligned access retires without a register write
        if ((state_q == S_IDLE) && is_mem && misaligned) begin
            mem_d.wb_ctrl.regf_we = 1'b0;
        end

        if (complete) begin
            if (is_load) begin
                mem_d.mem_rdata = load_ext;
            end
`ifdef MEM_STAGE_RVFI_MEM_EN
            mem_d.rvfi.mem_addr  = dmem_addr;
            mem_d.rvfi.mem_rmask = rvfi_rmask_q;
            mem_d.rvfi.mem_wmask = rvfi_wmask_q;
            mem_d.rvfi.mem_wdata = dmem_wdata;
            mem_d.rvfi.mem_rdata = dmem_rdata;
`endif
        end

        // bubble: keep rd_addr/alu_out moving but suppress write and retire
        if (o_mem_stall) begin
            mem_d.wb_ctrl.regf_we = 1'b0;
            mem_d.rvfi.valid      = 1'b0;
            mem_d.mem_rdata       = '0;
        end
    end

    // stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_stage_reg <= '0;
        end else begin
            mem_stage_reg <= mem_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops with
// random response latency, checked against a behavioural reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    ex_stage_t   ex_stage_reg;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        o_mem_stall;
    mem_stage_t  mem_stage_reg;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_stage_reg  (ex_stage_reg),
        .dmem_addr     (dmem_addr),
        .dmem_rmask    (dmem_rmask),
        .dmem_wmask    (dmem_wmask),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_resp     (dmem_resp),
        .o_mem_stall   (o_mem_stall),
        .mem_stage_reg (mem_stage_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the memory side must never answer in the issue cycle
    always @(negedge clk) begin
        if (rst_n && dmem_resp && ((dmem_rmask | dmem_wmask) != 4'd0)) begin
            errors++;
            $display("FAIL resp_in_issue: resp=%b rmask=%h wmask=%h required no resp with mask",
                     dmem_resp, dmem_rmask, dmem_wmask);
        end
    end

    // ---------------- reference model ----------------
    function automatic int access_bytes(input ex_stage_t ex);
        int nb;
        nb = 1 << int'(ex.mem_ctrl.funct3[1:0]);
        if (nb > 4) nb = 4;
        return nb;
    endfunction

    function automatic bit is_misaligned(input ex_stage_t ex);
        return (int'(ex.alu_out[1:0]) % access_bytes(ex)) != 0;
    endfunction

    function automatic bit is_memop(input ex_stage_t ex);
        return ex.mem_ctrl.mem_re || ex.mem_ctrl.mem_we;
    endfunction

    function automatic logic [3:0] exp_mask(input ex_stage_t ex);
        int unsigned m;
        m = ((1 << access_bytes(ex)) - 1) << int'(ex.alu_out[1:0]);
        return 4'(m);
    endfunction

    function automatic mem_stage_t model(input ex_stage_t ex, input logic [31:0] rdata);
        mem_stage_t      m;
        int              a;
        int              nb;
        longint unsigned raw, span, v;
        a  = int'(ex.alu_out[1:0]);
        nb = access_bytes(ex);
        m  = '0;
        m.alu_out       = ex.alu_out;
        m.rd_addr       = ex.rd_addr;
        m.wb_ctrl       = ex.wb_ctrl;
        m.rvfi.valid    = ex.rvfi.valid;
        m.rvfi.order    = ex.rvfi.order;
        m.rvfi.insn     = ex.rvfi.insn;
        m.rvfi.pc_rdata = ex.rvfi.pc_rdata;
        m.rvfi.pc_wdata = ex.rvfi.pc_wdata;
        if (!is_memop(ex)) return m;
        if (is_misaligned(ex)) begin
            m.wb_ctrl.regf_we = 1'b0;
            return m;
        end
        if (ex.mem_ctrl.mem_re) begin
            raw  = 64'(rdata) >> (8 * a);
            span = 64'd1 << (8 * nb);
            v    = raw % span;
            if (!ex.mem_ctrl.funct3[2] && nb < 4 && v >= span / 2)
                v = v + (64'h1_0000_0000 - span);
            m.mem_rdata = 32'(v);
        end
`ifdef MEM_STAGE_RVFI_MEM_EN
        m.rvfi.mem_addr  = ex.alu_out & 32'hFFFF_FFFC;
        m.rvfi.mem_rmask = ex.mem_ctrl.mem_re ? exp_mask(ex) : 4'd0;
        m.rvfi.mem_wmask = ex.mem_ctrl.mem_re ? 4'd0 : exp_mask(ex);
        m.rvfi.mem_wdata = 32'(64'(ex.rs2_rdata) << (8 * a));
        m.rvfi.mem_rdata = rdata;
`endif
        return m;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store
    function automatic ex_stage_t mk_op(input int kind, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] rs2,
                                        input logic [4:0] rd, input logic we);
        ex_stage_t ex;
        ex = '0;
        ex.alu_out          = addr;
        ex.rs2_rdata        = rs2;
        ex.rd_addr          = rd;
        ex.mem_ctrl.mem_re  = (kind == 1);
        ex.mem_ctrl.mem_we  = (kind == 2);
        ex.mem_ctrl.funct3  = f3;
        ex.wb_ctrl.regf_we  = (kind == 2) ? 1'b0 : we;
        ex.wb_ctrl.wb_sel   = (kind == 1) ? 2'd1 : 2'd0;
        ex.rvfi.valid       = 1'b1;
        ex.rvfi.order       = {32'd0, $urandom};
        ex.rvfi.insn        = $urandom;
        ex.rvfi.pc_rdata    = $urandom;
        ex.rvfi.pc_wdata    = $urandom;
        return ex;
    endfunction

    // ---------------- one op through the stage ----------------
    // Entered and left at posedge+1; resp arrives lat cycles after issue.
    task automatic run_op(input ex_stage_t ex, input int lat, input logic [31:0] rdata,
                          input string name);
        mem_stage_t exp;
        bit         issue;
        logic [3:0] m;
        int         stall_cycles;
        exp   = model(ex, rdata);
        issue = is_memop(ex) && !is_misaligned(ex);
        m     = issue ? exp_mask(ex) : 4'd0;
        ex_stage_reg = ex;
        stall_cycles = 0;
        @(negedge clk);
        checks++;
        if (dmem_rmask !== (ex.mem_ctrl.mem_re ? m : 4'd0) ||
            dmem_wmask !== (ex.mem_ctrl.mem_re ? 4'd0 : m)) begin
            errors++;
            $display("FAIL %s masks: got r=%h w=%h required r=%h w=%h", name, dmem_rmask,
                     dmem_wmask, ex.mem_ctrl.mem_re ? m : 4'd0, ex.mem_ctrl.mem_re ? 4'd0 : m);
        end
        checks++;
        if (dmem_addr !== (ex.alu_out & 32'hFFFF_FFFC) ||
            dmem_wdata !== 32'(64'(ex.rs2_rdata) << (8 * int'(ex.alu_out[1:0])))) begin
            errors++;
            $display("FAIL %s addr/wdata: got %h/%h", name, dmem_addr, dmem_wdata);
        end
        checks++;
        if (o_mem_stall !== issue) begin
            errors++;
            $display("FAIL %s issue_stall: got %b required %b", name, o_mem_stall, issue);
        end
        if (o_mem_stall === 1'b1) stall_cycles++;
        if (issue) begin
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk); #1;
                checks++;
                if (mem_stage_reg.wb_ctrl.regf_we !== 1'b0 || mem_stage_reg.rvfi.valid !== 1'b0 ||
                    mem_stage_reg.rd_addr !== ex.rd_addr || mem_stage_reg.alu_out !== ex.alu_out) begin
                    errors++;
                    $display("FAIL %s bubble%0d: got we=%b valid=%b rd=%0d alu=%h required 0/0/%0d/%h",
                             name, k, mem_stage_reg.wb_ctrl.regf_we, mem_stage_reg.rvfi.valid,
                             mem_stage_reg.rd_addr, mem_stage_reg.alu_out, ex.rd_addr, ex.alu_out);
                end
                if (k == lat) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = rdata;
                end
                @(negedge clk);
                checks++;
                if (o_mem_stall !== (k != lat) || dmem_rmask !== 4'd0 || dmem_wmask !== 4'd0) begin
                    errors++;
                    $display("FAIL %s wait%0d: got stall=%b r=%h w=%h required stall=%b masks 0",
                             name, k, o_mem_stall, dmem_rmask, dmem_wmask, k != lat);
                end
                if (o_mem_stall === 1'b1) stall_cycles++;
            end
        end
        @(posedge clk); #1;
        dmem_resp  = 1'b0;
        dmem_rdata = $urandom;
        checks++;
        if (stall_cycles != (issue ? lat : 0)) begin
            errors++;
            $display("FAIL %s stall_count: got %0d required %0d", name, stall_cycles,
                     issue ? lat : 0);
        end
        checks++;
        if (mem_stage_reg !== exp) begin
            errors++;
            $display("FAIL %s result: got %h required %h", name, mem_stage_reg, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        checks++;
        if (mem_stage_reg !== '0 || o_mem_stall !== 1'b0 || dmem_rmask !== 4'd0 ||
            dmem_wmask !== 4'd0 || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset: got reg=%h stall=%b r=%h w=%h required all zero",
                     mem_stage_reg, o_mem_stall, dmem_rmask, dmem_wmask);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(mk_op(1, 3'b010, 32'h100, 32'h0, 5'd3, 1'b1), 1, 32'hDEADBEEF, "lw_0x100");
        checks++;
        if (mem_stage_reg.mem_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_rdata: got %h required DEADBEEF", mem_stage_reg.mem_rdata);
        end
        run_op(mk_op(1, 3'b000, 32'h103, 32'h0, 5'd4, 1'b1), 2, 32'h80123456, "lb_0x103");
        checks++;
        if (mem_stage_reg.mem_rdata !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_rdata: got %h required FFFFFF80", mem_stage_reg.mem_rdata);
        end
        run_op(mk_op(1, 3'b100, 32'h103, 32'h0, 5'd5, 1'b1), 1, 32'h80123456, "lbu_0x103");
        checks++;
        if (mem_stage_reg.mem_rdata !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu_rdata: got %h required 00000080", mem_stage_reg.mem_rdata);
        end
        run_op(mk_op(2, 3'b001, 32'h202, 32'h00001234, 5'd6, 1'b0), 1, 32'h0, "sh_0x202");
        checks++;
        if (mem_stage_reg.wb_ctrl.regf_we !== 1'b0) begin
            errors++;
            $display("FAIL sh_regf_we: got %b required 0", mem_stage_reg.wb_ctrl.regf_we);
        end
        run_op(mk_op(1, 3'b010, 32'h1001, 32'h0, 5'd7, 1'b1), 1, 32'h0, "lw_misaligned");
        run_op(mk_op(1, 3'b001, 32'h303, 32'h0, 5'd8, 1'b1), 1, 32'h0, "lh_misaligned");
    endtask

    task automatic test_back_to_back();
        run_op(mk_op(1, 3'b010, 32'h400, 32'h0, 5'd9, 1'b1), 4, 32'h13579BDF, "lw_lat4");
        run_op(mk_op(0, 3'b000, 32'h0000_0042, 32'h0, 5'd10, 1'b1), 1, 32'h0, "add_after");
        run_op(mk_op(2, 3'b010, 32'h500, 32'hCAFEF00D, 5'd0, 1'b0), 1, 32'h0, "sw_b2b");
        run_op(mk_op(1, 3'b101, 32'h502, 32'h0, 5'd11, 1'b1), 3, 32'h8765_4321, "lhu_b2b");
        run_op(mk_op(1, 3'b001, 32'h502, 32'h0, 5'd12, 1'b1), 1, 32'h8765_4321, "lh_b2b");
    endtask

    task automatic test_random();
        int          kind;
        logic [2:0]  f3;
        logic [2:0]  ld_f3 [5];
        ex_stage_t   ex;
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
        ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            f3   = (kind == 2) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            ex   = mk_op(kind, f3, $urandom, $urandom, 5'($urandom), 1'($urandom));
            run_op(ex, int'($urandom_range(1, 4)), $urandom, "random");
        end
    endtask

    task automatic test_reset_in_wait();
        ex_stage_t add_op;
        mem_stage_t exp;
        ex_stage_reg = mk_op(1, 3'b010, 32'h600, 32'h0, 5'd13, 1'b1);
        @(posedge clk); #1;
        ex_stage_reg = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_mem_stall !== 1'b0 || mem_stage_reg !== '0 || dmem_rmask !== 4'd0) begin
            errors++;
            $display("FAIL reset_in_wait: got stall=%b reg=%h required 0", o_mem_stall, mem_stage_reg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (o_mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL stray_resp_stall: got %b required 0", o_mem_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_stage_reg !== '0) begin
            errors++;
            $display("FAIL stray_resp_reg: got %h required 0", mem_stage_reg);
        end
        add_op = mk_op(0, 3'b000, 32'h77, 32'h0, 5'd14, 1'b1);
        exp = model(add_op, 32'h0);
        ex_stage_reg = add_op;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        checks++;
        if (mem_stage_reg !== exp) begin
            errors++;
            $display("FAIL stray_resp_add: got %h required %h", mem_stage_reg, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        ex_stage_reg = '0;
        dmem_resp    = 1'b0;
        dmem_rdata   = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
